// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M by driving an
// external Montgomery multiplier (one MontMul per ISSUE/WAIT pair).
module mont_exp_ctrl #(
  parameter int W  = 1024,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_e,
  input  logic [CW-1:0] e_len,
  input  logic [W-1:0]  in_m,
  input  logic [W-1:0]  in_r,
  input  logic [W-1:0]  in_r2,
  output logic [W-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          mm_start,
  output logic [W-1:0]  mm_a,
  output logic [W-1:0]  mm_b,
  output logic [W-1:0]  mm_m,
  input  logic [W-1:0]  mm_result,
  input  logic          mm_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_PRE, OP_SQ, OP_MUL, OP_POST} op_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t        state;
  op_t           op;
  logic [W-1:0]  e_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  xt_q;

  logic          e_bit;
  op_t           nxt_op;
  logic [W-1:0]  nxt_a;
  logic [W-1:0]  nxt_b;
  logic          nxt_fin;
  logic          nxt_dec;

  assign e_bit = |(e_q & (ONE << idx));

  // Next operation and its operands, valid on the mm_done cycle of WAIT. The
  // freshly produced mm_result feeds the next operands directly so the next
  // mm_start can follow mm_done by a single cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nxt_op  = OP_POST;
    nxt_a   = mm_result;
    nxt_b   = ONE;
    nxt_fin = 1'b0;
    nxt_dec = 1'b0;
    case (op)
      OP_PRE: begin
        nxt_a = a_q;
        if (len_q != '0) begin
          nxt_op = OP_SQ;
          nxt_b  = a_q;
        end
      end
      OP_SQ, OP_MUL: begin
        if (op == OP_SQ && e_bit) begin
          nxt_op = OP_MUL;
          nxt_b  = xt_q;
        end else if (idx != '0) begin
          nxt_op  = OP_SQ;
          nxt_b   = mm_result;
          nxt_dec = 1'b1;
        end
      end
      OP_POST: begin
        nxt_fin = 1'b1;
        nxt_a   = '0;
        nxt_b   = '0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= OP_PRE;
      e_q      <= '0;
      len_q    <= '0;
      idx      <= '0;
      a_q      <= '0;
      xt_q     <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            // The PRE operands registers double as the latches for X and R2.
            e_q      <= in_e;
            len_q    <= e_len;
            idx      <= e_len - CW'(1);
            a_q      <= in_r;
            op       <= OP_PRE;
            mm_a     <= in_x;
            mm_b     <= in_r2;
            mm_m     <= in_m;
            mm_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mm_done) begin
            if (op == OP_PRE) xt_q <= mm_result;
            else              a_q  <= mm_result;
            if (op == OP_POST) result <= mm_result;
            if (nxt_dec) idx <= idx - CW'(1);
            mm_a <= nxt_a;
            mm_b <= nxt_b;
            if (nxt_fin) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              op       <= nxt_op;
              mm_start <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with W=8, M=239 and a fixed-latency (L=5)
// behavioural Montgomery multiplier returning a*b*256^-1 mod 239.
module tb_mont_exp_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int L  = 5;
  localparam int RINV = 225;  // 256^-1 mod 239

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_e = '0;
  logic [CW-1:0] e_len = '0;
  logic [W-1:0]  in_m = 8'd239;
  logic [W-1:0]  in_r = 8'd17;
  logic [W-1:0]  in_r2 = 8'd50;
  logic [W-1:0]  result;
  logic          done;
  logic          busy;
  logic          mm_start;
  logic [W-1:0]  mm_a;
  logic [W-1:0]  mm_b;
  logic [W-1:0]  mm_m;
  logic [W-1:0]  mm_result;
  logic          mm_done;

  logic          model_done = 1'b0;
  logic [W-1:0]  model_res = '0;
  logic          stray_done = 1'b0;
  logic [W-1:0]  ma = '0;
  logic [W-1:0]  mb = '0;
  int            cnt = 0;

  int checks = 0;
  int errors = 0;

  assign mm_result = model_res;
  assign mm_done   = model_done | stray_done;

  mont_exp_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .e_len(e_len), .in_m(in_m),
    .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  // Multiplier model: mm_start in cycle t gives mm_done and the product in t+L.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset) begin
      cnt <= 0;
    end else if (mm_start) begin
      ma  <= mm_a;
      mb  <= mm_b;
      cnt <= L - 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        model_done <= 1'b1;
        model_res  <= W'((int'(ma) * int'(mb) * RINV) % 239);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One exponentiation; glitch_at > 0 re-pulses start (with other operands) mid-run.
  task automatic run_exp(input string tag, input logic [W-1:0] x, input logic [W-1:0] e,
                         input logic [CW-1:0] len, input logic [W-1:0] exp_res,
                         input int exp_pulses, input int exp_lat, input int glitch_at);
    int pulses = 0;
    int lat = -1;
    logic prev_start = 1'b0;
    logic outstanding = 1'b0;
    logic [3*W-1:0] held = '0;
    @(negedge clk);
    in_x = x; in_e = e; e_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (mm_start) begin
        pulses++;
        check({tag, "_start_gap"}, {30'd0, prev_start, mm_start}, 32'd1);
        check({tag, "_mm_m"}, 32'(mm_m), 32'd239);
        if (pulses == 1) check({tag, "_pre_ops"}, {16'd0, mm_a, mm_b}, {16'd0, x, 8'd50});
        held = {mm_a, mm_b, mm_m};
        outstanding = 1'b1;
      end else if (outstanding) begin
        check({tag, "_op_hold"}, 32'({mm_a, mm_b, mm_m}), 32'(held));
      end
      if (mm_done) outstanding = 1'b0;
      prev_start = mm_start;
      if (done) begin
        lat = k;
        break;
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      start = (k + 1 == glitch_at);
      if (k + 1 == glitch_at) begin
        in_x = 8'd3; in_e = 8'hFF; e_len = 4'd8;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {28'd0, done, busy, mm_start, 1'b0}, 32'd0);
    check("rst_ops", 32'({mm_a, mm_b, mm_m}), 32'd0);
    reset = 1'b0;

    run_exp("x5_e3", 8'd5, 8'd3, 4'd2, 8'd125, 6, 37, 0);
    run_exp("x2_e11", 8'd2, 8'b1011, 4'd4, 8'd136, 9, 55, 10);
    run_exp("elen0", 8'd7, 8'hFF, 4'd0, 8'd1, 2, 13, 0);

    // Stray multiplier done while idle must not disturb anything.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("stray_busy", {30'd0, busy, mm_start}, 32'd0);
    @(negedge clk);
    check("stray_after", {30'd0, busy, mm_start}, 32'd0);
    check("stray_result", 32'(result), 32'd1);

    // Reset during the third WAIT.
    @(negedge clk);
    in_x = 8'd5; in_e = 8'd3; e_len = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      if (mm_start) pulses++;
      if (pulses == 3) break;
      @(negedge clk);
    end
    check("rst_pulses", 32'(pulses), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", {30'd0, done, mm_start}, 32'd0);
    reset = 1'b0;

    run_exp("after_rst", 8'd5, 8'd3, 4'd2, 8'd125, 6, 37, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
